// File: rtl/param_step.sv
// Configurable step unit: adds/subtracts a constant STEP to an operand under a
// start/done handshake, with wrap, saturate and iterated-add modes.
module param_step #(
  parameter int WIDTH = 8,
  parameter int STEP  = 3,
  parameter int REP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [REP_W-1:0]   reps,
  input  logic [WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]   out_data,
  output logic               done,
  output logic               busy,
  output logic               ovf
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [REP_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               flag_q, flag_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // The extra top bit carries the carry-out of the add and the borrow of the subtract.
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;

  assign sum_ext  = {1'b0, acc_q} + {1'b0, STEP_W};
  assign diff_ext = {1'b0, acc_q} - {1'b0, STEP_W};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    flag_d     = flag_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = in_data;
          mode_d  = mode;
          flag_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = (mode == 2'd3) ? reps : REP_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - REP_W'(1);
          case (mode_q)
            2'd1: begin
              acc_d  = diff_ext[WIDTH-1:0];
              flag_d = flag_q | diff_ext[WIDTH];
            end
            2'd2: begin
              if (sum_ext[WIDTH]) begin
                acc_d  = '1;
                flag_d = 1'b1;
              end else begin
                acc_d  = sum_ext[WIDTH-1:0];
              end
            end
            default: begin
              // Modes 0 and 3 share the wrapping add; flag stays sticky over iterations.
              acc_d  = sum_ext[WIDTH-1:0];
              flag_d = flag_q | sum_ext[WIDTH];
            end
          endcase
        end else begin
          out_data_d = acc_q;
          ovf_d      = flag_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      flag_q     <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      flag_q     <= flag_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign out_data = out_data_q;
  assign ovf      = ovf_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_param_step.sv
// Bench for param_step: directed cases, handshake/reset scenarios and random
// operations checked against an arithmetic reference model.
module tb_param_step;

  localparam int WIDTH = 8;
  localparam int STEP  = 3;
  localparam int REP_W = 4;
  localparam int MODV  = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [REP_W-1:0] reps;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic             done;
  logic             busy;
  logic             ovf;

  int n_cmp = 0;
  int n_err = 0;

  param_step #(.WIDTH(WIDTH), .STEP(STEP), .REP_W(REP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .reps     (reps),
    .in_data  (in_data),
    .out_data (out_data),
    .done     (done),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Whole-operation model: the net effect of r iterated steps is one add of r*STEP,
  // and a sticky carry is set exactly when that total reaches 2**WIDTH.
  task automatic model(input int m, input int r, input int d, output int res, output int o);
    int s;
    case (m)
      0: begin s = d + STEP;     o = (s >= MODV) ? 1 : 0; res = s % MODV; end
      1: begin s = d - STEP;     o = (s < 0) ? 1 : 0;     res = (s + MODV) % MODV; end
      2: begin s = d + STEP;     o = (s >= MODV) ? 1 : 0; res = o ? MODV - 1 : s; end
      default: begin s = d + r * STEP; o = (s >= MODV) ? 1 : 0; res = s % MODV; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int m, input int r, input int d, input bit scramble);
    int exp_d, exp_o, n, cyc, gaps;
    bit seen;
    model(m, r, d, exp_d, exp_o);
    n = (m == 3) ? r : 1;
    mode    = 2'(m);
    reps    = REP_W'(r);
    in_data = WIDTH'(d);
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);
    cyc = 0; gaps = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (scramble) begin
        mode    = 2'($urandom);
        reps    = REP_W'($urandom);
        in_data = WIDTH'($urandom);
      end
      tick();
      cyc++;
      if (done) seen = 1'b1;
      else if (!busy) gaps++;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      return;
    end
    $display("op mode=%0d reps=%0d in=%0d -> out=%0d ovf=%0d lat=%0d (exp out=%0d ovf=%0d lat=%0d)",
             m, r, d, out_data, ovf, cyc, exp_d, exp_o, n + 1);
    chk("latency", cyc, n + 1);
    chk("busy_gap", gaps, 0);
    chk("busy_with_done", int'(busy), 0);
    chk("out_data", int'(out_data), exp_d);
    chk("ovf", int'(ovf), exp_o);
    tick();
    chk("done_width", int'(done), 0);
    chk("hold_out", int'(out_data), exp_d);
    chk("hold_ovf", int'(ovf), exp_o);
  endtask

  initial begin
    int dn_cnt, last_dn, prev_dn, width_bad, both_bad;
    rst_n = 1'b0; start = 1'b0; mode = '0; reps = '0; in_data = '0;
    #2;
    chk("rst_out", int'(out_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(busy), 0);

    // Directed cases
    do_op(0, 0, 5, 1'b0);
    do_op(0, 0, 254, 1'b0);
    do_op(1, 0, 1, 1'b0);
    do_op(2, 0, 250, 1'b0);
    do_op(2, 0, 10, 1'b0);
    do_op(3, 4, 10, 1'b0);
    do_op(3, 3, 250, 1'b0);
    do_op(3, 0, 77, 1'b0);
    do_op(3, 15, 255, 1'b1);
    do_op(1, 0, 3, 1'b0);

    // Start pulsed during RUN must be ignored
    mode = 2'd3; reps = 4'd4; in_data = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; in_data = 8'd0; mode = 2'd0;
    tick();
    start = 1'b0;
    dn_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dn_cnt++;
    end
    $display("ignored-start: dones=%0d out=%0d", dn_cnt, out_data);
    chk("ignored_start_dones", dn_cnt, 1);
    chk("ignored_start_out", int'(out_data), 22);

    // Start held high: one accepted operation every reps+2 cycles
    mode = 2'd3; reps = 4'd4; in_data = 8'd10; start = 1'b1;
    dn_cnt = 0; last_dn = -1; prev_dn = -1; width_bad = 0; both_bad = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (done && busy) both_bad++;
      if (done) begin
        if (last_dn == k - 1) width_bad++;
        if (last_dn >= 0) chk("held_spacing", k - last_dn, 6);
        prev_dn = last_dn;
        last_dn = k;
        dn_cnt++;
      end
    end
    start = 1'b0;
    $display("held-start: dones=%0d last=%0d out=%0d", dn_cnt, last_dn, out_data);
    chk("held_dones", dn_cnt, 4);
    chk("held_width", width_bad, 0);
    chk("held_busy_done", both_bad, 0);
    chk("held_out", int'(out_data), 22);
    tick(); tick();

    // Reset in the middle of an operation
    mode = 2'd3; reps = 4'd8; in_data = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    $display("mid-op reset: out=%0d done=%0d busy=%0d ovf=%0d", out_data, done, busy, ovf);
    chk("midrst_out", int'(out_data), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    tick(); tick();
    rst_n = 1'b1;
    dn_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dn_cnt++;
    end
    chk("midrst_no_done", dn_cnt, 0);
    do_op(0, 0, 5, 1'b0);

    // Random operations with inputs scrambled while busy
    for (int t = 0; t < 40; t++) begin
      int gap;
      do_op(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
            int'($urandom_range(255, 0)), 1'($urandom));
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
